// File: rtl/tcp_tx_state_machine_if.sv
// Bundle of the handshake and data signals of the TCP transmit connection initiator.
// Latency: none (wiring only).
// Backpressure: TX_DATA_READY flows from slave to master; other signals are strobes.
//
// master: request/close pulses, receive-path packet strobe, outbound order payload.
// slave : the state machine; returns ready, packet strobe/word and status flags.
interface tcp_tx_state_machine_if;
  logic        CONNECT;
  logic        CLOSE;
  logic        RX_PACKET_READY;
  logic [31:0] RX_PAYLOAD_DATA;
  logic        TX_DATA_VALID;
  logic [23:0] TX_DATA;
  logic        TX_DATA_READY;
  logic        PACKET_READY_OUT;
  logic [31:0] PAYLOAD_DATA_OUT;
  logic        CONNECTED;
  logic        CONN_FAILED;

  modport master (
    output CONNECT, CLOSE, RX_PACKET_READY, RX_PAYLOAD_DATA, TX_DATA_VALID, TX_DATA,
    input  TX_DATA_READY, PACKET_READY_OUT, PAYLOAD_DATA_OUT, CONNECTED, CONN_FAILED
  );

  modport slave (
    input  CONNECT, CLOSE, RX_PACKET_READY, RX_PAYLOAD_DATA, TX_DATA_VALID, TX_DATA,
    output TX_DATA_READY, PACKET_READY_OUT, PAYLOAD_DATA_OUT, CONNECTED, CONN_FAILED
  );
endinterface

// File: rtl/tcp_tx_state_machine.sv
// TCP transmit-side connection initiator: SYN/SYN+ACK/ACK open, SYN retransmit, data framing, FIN+ACK close.
// Latency: one cycle from input event (CONNECT, RX packet, TX accept, CLOSE) to registered packet strobe.
// Backpressure: TX_DATA_READY is high only in EST without CLOSE; a same-cycle peer FIN drops accepted data.
//
// Ports: CLK, RESET_N (async active-low) plus the slave side of tcp_tx_state_machine_if.
// Packet word: [31:24] flags (bit0 SYN, bit1 ACK, bit2 FIN), [23:0] payload.
module tcp_tx_state_machine #(
  parameter int SYN_TIMEOUT = 1000,
  parameter int MAX_RETRIES = 3
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  tcp_tx_state_machine_if.slave   bus
);

  localparam int TW = $clog2(SYN_TIMEOUT + 1);
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [31:0] PKT_SYN     = 32'h0100_0000;
  localparam logic [31:0] PKT_ACK     = 32'h0200_0000;
  localparam logic [31:0] PKT_FIN_ACK = 32'h0600_0000;
  localparam logic [7:0]  FLAGS_DATA  = 8'h02;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYN_SENT,
    S_EST,
    S_FAILED
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          pkt_vld_q, pkt_vld_d;
  logic [31:0]   pkt_dat_q, pkt_dat_d;
  logic          connected_q, connected_d;
  logic          failed_q, failed_d;

  logic [7:0]    rx_flags;
  logic          rx_syn_ack;
  logic          rx_fin;
  logic          tx_rdy;
  logic          tx_accept;
  logic          timeout;
  logic          unused_rx;

  assign rx_flags   = bus.RX_PAYLOAD_DATA[31:24];
  assign rx_syn_ack = bus.RX_PACKET_READY & rx_flags[0] & rx_flags[1];
  assign rx_fin     = bus.RX_PACKET_READY & rx_flags[2];
  assign tx_rdy     = (state_q == S_EST) & ~bus.CLOSE;
  assign tx_accept  = bus.TX_DATA_VALID & tx_rdy;
  // Timer is cleared on the SYN edge, so reaching SYN_TIMEOUT-1 here means the
  // next edge is exactly SYN_TIMEOUT cycles after the SYN strobe.
  assign timeout    = (timer_q == TW'(SYN_TIMEOUT - 1));
  assign unused_rx  = ^{bus.RX_PAYLOAD_DATA[31:27], bus.RX_PAYLOAD_DATA[23:0]};

  always_comb begin
    state_d   = state_q;
    timer_d   = '0;
    retry_d   = retry_q;
    pkt_vld_d = 1'b0;
    pkt_dat_d = pkt_dat_q;

    case (state_q)
      S_IDLE, S_FAILED: begin
        if (bus.CONNECT) begin
          pkt_vld_d = 1'b1;
          pkt_dat_d = PKT_SYN;
          retry_d   = '0;
          state_d   = S_SYN_SENT;
        end
      end

      S_SYN_SENT: begin
        // SYN+ACK takes priority over a coincident timeout.
        if (rx_syn_ack) begin
          pkt_vld_d = 1'b1;
          pkt_dat_d = PKT_ACK;
          state_d   = S_EST;
        end else if (timeout) begin
          if (retry_q < RW'(MAX_RETRIES)) begin
            pkt_vld_d = 1'b1;
            pkt_dat_d = PKT_SYN;
            retry_d   = retry_q + 1'b1;
          end else begin
            state_d   = S_FAILED;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end

      S_EST: begin
        // CLOSE and peer FIN share one FIN+ACK; a data word accepted in the
        // same cycle as a peer FIN is dropped.
        if (bus.CLOSE || rx_fin) begin
          pkt_vld_d = 1'b1;
          pkt_dat_d = PKT_FIN_ACK;
          state_d   = S_IDLE;
        end else if (tx_accept) begin
          pkt_vld_d = 1'b1;
          pkt_dat_d = {FLAGS_DATA, bus.TX_DATA};
        end
      end

      default: state_d = S_IDLE;
    endcase

    connected_d = (state_d == S_EST);
    failed_d    = (state_d == S_FAILED);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      retry_q     <= '0;
      pkt_vld_q   <= 1'b0;
      pkt_dat_q   <= '0;
      connected_q <= 1'b0;
      failed_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      pkt_vld_q   <= pkt_vld_d;
      pkt_dat_q   <= pkt_dat_d;
      connected_q <= connected_d;
      failed_q    <= failed_d;
    end
  end

  assign bus.TX_DATA_READY    = tx_rdy;
  assign bus.PACKET_READY_OUT = pkt_vld_q;
  assign bus.PAYLOAD_DATA_OUT = pkt_dat_q;
  assign bus.CONNECTED        = connected_q;
  assign bus.CONN_FAILED      = failed_q;

endmodule

// File: doc/tcp_tx_state_machine.md
Name: tcp_tx_state_machine

Overview:
Transmit-side TCP connection initiator for the trading link. On request it opens a connection by sending SYN and waiting for SYN+ACK from the receive path, then sends ACK. Once established it wraps outbound order words into flagged 32-bit packets. It retransmits SYN on timeout, gives up after a bounded number of retries, and closes with FIN+ACK. Packet word format: [31:24] flags (bit0 SYN, bit1 ACK, bit2 FIN, others 0), [23:0] payload.

Parameters:
SYN_TIMEOUT, 1000, cycles from a SYN emission to its retransmission if no SYN+ACK arrives (>=2)
MAX_RETRIES, 3, number of SYN retransmissions allowed before declaring failure (>=0)

Ports:
CLK  in  1  system clock, rising edge
RESET_N  in  1  asynchronous active-low reset
CONNECT  in  1  single-cycle pulse; open a connection (honoured in IDLE/FAILED only)
CLOSE  in  1  single-cycle pulse; close connection (honoured in EST only)
RX_PACKET_READY  in  1  valid strobe for a packet from the receive path
RX_PAYLOAD_DATA  in  32  received packet word; flags in [31:24]
TX_DATA_VALID  in  1  order payload valid
TX_DATA  in  24  order payload
TX_DATA_READY  out  1  combinational: (state==EST) & ~CLOSE
PACKET_READY_OUT  out  1  registered one-cycle strobe per emitted packet
PAYLOAD_DATA_OUT  out  32  registered packet word; holds last value between strobes
CONNECTED  out  1  registered; 1 while in EST
CONN_FAILED  out  1  registered; 1 while in FAILED

Behaviour:
- Reset (RESET_N low, async): state IDLE; PACKET_READY_OUT=0, PAYLOAD_DATA_OUT=0, CONNECTED=0, CONN_FAILED=0, timer=0, retry count=0. Reset mid-handshake or mid-stream aborts with no further output.
- PACKET_READY_OUT defaults to 0 every cycle. At most one packet is emitted per cycle.
- IDLE / FAILED: if CONNECT, set PAYLOAD_DATA_OUT=0x01000000 (SYN), pulse PACKET_READY_OUT, clear retry count, load timer, go SYN_SENT. CONN_FAILED clears on leaving FAILED.
- SYN_SENT:
  - RX_PACKET_READY with flags[0]=1 and flags[1]=1: emit 0x02000000 (ACK), go EST. CONNECTED=1 from the same edge.
  - RX packets with other flag combinations are ignored.
  - Timeout: retransmit occurs exactly SYN_TIMEOUT cycles after the previous SYN strobe.
    - If retry count < MAX_RETRIES: re-emit SYN, increment count, reload timer.
    - Otherwise go FAILED with no emission.
  - SYN+ACK arriving in the same cycle as a timeout: SYN+ACK wins; no retransmit.
  - CONNECT and CLOSE are ignored.
- EST:
  - Handshake: accepted when TX_DATA_VALID & TX_DATA_READY.
  - Next edge: PAYLOAD_DATA_OUT={8'h02, TX_DATA}, PACKET_READY_OUT=1. Latency 1 cycle. Throughput 1 word/cycle back-to-back.
  - CLOSE: emit 0x06000000 (FIN+ACK), go IDLE, CONNECTED=0. TX_DATA_READY is low that cycle, so any concurrent TX data is not accepted.
  - RX packet with flags[2]=1 (peer FIN): emit 0x06000000, go IDLE. If a TX handshake completes in the same cycle, the FIN+ACK emission wins and the data is dropped. The driver must treat ready as advisory for that cycle.
  - CLOSE together with peer FIN: a single FIN+ACK is emitted.
- Timer width: $clog2(SYN_TIMEOUT+1). It counts only in SYN_SENT.
- Retry counter width: $clog2(MAX_RETRIES+1), minimum 1. It saturates and never wraps.

Test Plan:
(SYN_TIMEOUT=8, MAX_RETRIES=2 unless noted)
- Reset checks:
  - Assert RESET_N=0 with random inputs -> all outputs 0.
  - Release RESET_N, pulse CONNECT -> next edge PACKET_READY_OUT=1, PAYLOAD_DATA_OUT=0x01000000.
- Normal open and data path:
  - After SYN, drive an RX packet with flags 0x03 at cycle 3 -> one strobe with 0x02000000, then CONNECTED=1.
  - Stream TX_DATA 0x000001, 0x000002, 0x000003 back-to-back -> strobes with 0x02000001/2/3 on consecutive cycles, each 1 cycle after acceptance.
- Retransmit and failure:
  - With no RX packets, SYN strobes appear at t, t+8, t+16.
  - At t+24: state FAILED, CONN_FAILED=1, no 4th SYN.
  - CONNECT from FAILED -> SYN, CONN_FAILED=0.
- Timeout collision:
  - SYN+ACK arrives exactly at t+8 -> one ACK strobe only, no retransmit, CONNECTED=1.
  - RX flags 0x01 in SYN_SENT -> ignored.
- Close paths:
  - In EST, CLOSE asserted with TX_DATA_VALID=1 -> TX_DATA_READY=0, one 0x06000000 strobe, state IDLE, CONNECTED=0.
  - Repeat using peer FIN (RX flags 0x04) -> same response.
- Async reset mid-stream:
  - Drop RESET_N between clock edges during EST streaming -> outputs clear immediately, without waiting for a clock edge.
  - After release, no strobe occurs until the next CONNECT.
